// File: rtl/dmem_port_arbiter_if.sv
// Requester-side handshake bundle for the data-memory port arbiter.
//   req/we/addr/wdata : request driven by the requester, held until gnt
//   gnt               : request accepted this cycle
//   rvalid/rdata      : read data returned for a previously granted read
// The master modport is the requester's view; slave is the arbiter's view.
interface dmem_port_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-cycle data SRAM port between two requesters
// (m0 = processor load/store path, m1 = loader/debug DMA) using
// round-robin arbitration. The grant and the memory command are combinational
// in the request cycle. Read data is steered back to whichever requester issued
// the read, RD_LAT cycles later.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   m0, m1          requester handshake bundles (dmem_port_if.slave)
//   CEN/WEN/OEN     SRAM chip/write/output enables, active low
//   A, Data2Mem     SRAM word address and write data
//   ReadDataMem     SRAM read data, valid RD_LAT cycles after OEN=0
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_port_if.slave        m0,
   dmem_port_if.slave        m1,
   output logic              CEN,
   output logic              WEN,
   output logic              OEN,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] Data2Mem,
   input  logic [DATA_W-1:0] ReadDataMem
);

   // Index of the most recent winner; the other requester wins the next tie.
   logic              rr_last;
   logic              gnt0_c;
   logic              gnt1_c;
   logic              rd_gnt_c;
   logic              rv0_c;
   logic              rv1_c;
   // Read-return tag pipe: one {valid, id} entry per cycle of read latency.
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_id;

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (rst_n) begin
         if (m0.req && m1.req) begin
            gnt0_c = rr_last;
            gnt1_c = !rr_last;
         end else begin
            gnt0_c = m0.req;
            gnt1_c = m1.req;
         end
      end
      rd_gnt_c = (gnt0_c && !m0.we) || (gnt1_c && !m1.we);
   end

   // Memory command for the granted requester; idle port parks at all-inactive.
   always_comb begin
      CEN      = 1'b1;
      WEN      = 1'b1;
      OEN      = 1'b1;
      A        = '0;
      Data2Mem = '0;
      if (gnt0_c) begin
         CEN      = 1'b0;
         WEN      = !m0.we;
         OEN      = m0.we;
         A        = m0.addr;
         Data2Mem = m0.wdata;
      end else if (gnt1_c) begin
         CEN      = 1'b0;
         WEN      = !m1.we;
         OEN      = m1.we;
         A        = m1.addr;
         Data2Mem = m1.wdata;
      end
   end

   // Return path: the tag leaving the pipe selects which requester sees data.
   always_comb begin
      rv0_c     = rst_n && tag_vld[RD_LAT-1] && !tag_id[RD_LAT-1];
      rv1_c     = rst_n && tag_vld[RD_LAT-1] &&  tag_id[RD_LAT-1];
      m0.gnt    = gnt0_c;
      m1.gnt    = gnt1_c;
      m0.rvalid = rv0_c;
      m1.rvalid = rv1_c;
      m0.rdata  = rv0_c ? ReadDataMem : '0;
      m1.rdata  = rv1_c ? ReadDataMem : '0;
   end

   // Round-robin pointer and read-tag pipe; reset drops any reads in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_last <= 1'b1;
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         if (gnt0_c || gnt1_c) begin
            rr_last <= gnt1_c;
         end
         for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
         tag_vld[0] <= rd_gnt_c;
         tag_id[0]  <= gnt1_c;
      end
   end

endmodule
